// File: rtl/comb_bist.sv
// Exhaustive self-tester for a small combinational block: it steps stim through
// every input vector, checks resp against a truth table and reports the results.
module comb_bist #(
  parameter int unsigned N_INPUTS = 3,
  parameter logic [(2**N_INPUTS)-1:0] EXPECTED = 8'h12,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [N_INPUTS-1:0] stim,
  input  logic                resp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                error,
  output logic [N_INPUTS:0]   error_count,
  output logic [N_INPUTS:0]   total_tests,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned CW = N_INPUTS + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                error_q, error_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;
  logic [CW-1:0]       total_q, total_d;
  logic [N_INPUTS-1:0] ffv_q, ffv_d;
  logic                ffvalid_q, ffvalid_d;

  // State and result registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      stim_q    <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      total_q   <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      total_q   <= total_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Next-state and result update.
  always_comb begin
    state_d   = state_q;
    stim_d    = stim_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    total_d   = total_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          stim_d    = '0;
          settle_d  = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_cnt_d = '0;
          total_d   = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      ST_APPLY: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        total_d = total_q + CW'(1);
        if (resp != EXPECTED[stim_q]) begin
          err_cnt_d = err_cnt_q + CW'(1);
          error_d   = 1'b1;
          if (!ffvalid_q) begin
            ffv_d     = stim_q;
            ffvalid_d = 1'b1;
          end
        end
        if (&stim_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d  = ST_APPLY;
          stim_d   = stim_q + N_INPUTS'(1);
          settle_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign error            = error_q;
  assign error_count      = err_cnt_q;
  assign total_tests      = total_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_comb_bist.sv
// Directed bench for comb_bist: a default-parameter instance and a 2-input,
// 1-settle-cycle instance, each driven by a selectable DUT model.
module tb_comb_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b;

  logic [2:0] stim_a;
  logic       resp_a, busy_a, done_a, pass_a, err_a, ffvalid_a;
  logic [3:0] ec_a, tt_a;
  logic [2:0] ffv_a;

  logic [1:0] stim_b;
  logic       resp_b, busy_b, done_b, pass_b, err_b, ffvalid_b;
  logic [2:0] ec_b, tt_b;
  logic [1:0] ffv_b;

  comb_bist u_a (
    .clk(clk), .reset(reset), .start(start_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .error(err_a),
    .error_count(ec_a), .total_tests(tt_a), .first_fail_vec(ffv_a),
    .first_fail_valid(ffvalid_a)
  );

  comb_bist #(.N_INPUTS(2), .EXPECTED(4'h8), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .error(err_b),
    .error_count(ec_b), .total_tests(tt_b), .first_fail_vec(ffv_b),
    .first_fail_valid(ffvalid_b)
  );

  // DUT models: a 0 good, 1 stuck-at-0, 2 inverted, 3 good only in CHECK; b 0 AND, 1 OR
  int   mode_a, mode_b;
  logic apply_ph;
  logic good_a;
  always_comb begin
    good_a = (stim_a == 3'd1) || (stim_a == 3'd4);
    case (mode_a)
      0:       resp_a = good_a;
      1:       resp_a = 1'b0;
      2:       resp_a = ~good_a;
      default: resp_a = apply_ph ? ~good_a : good_a;
    endcase
    resp_b = (mode_b == 0) ? (stim_b[1] & stim_b[0]) : (stim_b[1] | stim_b[0]);
  end

  int   sel;
  logic o_busy, o_done, o_pass, o_err, o_ffvalid;
  int   o_stim, o_ec, o_tt, o_ffv;
  always_comb begin
    if (sel == 0) begin
      o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_err = err_a; o_ffvalid = ffvalid_a;
      o_stim = int'(stim_a); o_ec = int'(ec_a); o_tt = int'(tt_a); o_ffv = int'(ffv_a);
    end else begin
      o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_err = err_b; o_ffvalid = ffvalid_b;
      o_stim = int'(stim_b); o_ec = int'(ec_b); o_tt = int'(tt_b); o_ffv = int'(ffv_b);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One run: pulse (or hold) start, trace stim and error pulses until done.
  task automatic run_test(input int s, input bit hold, input int max_c,
                          output int done_c, output logic [63:0] mask, output int stim_bad);
    int sp1, nv;
    sel = s;
    sp1 = (s == 0) ? 3 : 2;
    nv  = (s == 0) ? 8 : 4;
    done_c = 0; mask = '0; stim_bad = 0;
    @(negedge clk);
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      apply_ph = (c % sp1) != 0;
      if (c == 1) begin
        check("start_done_clr", longint'(o_done), 0);
        check("start_busy", longint'(o_busy), 1);
        check("start_counts_clr", longint'(o_ec + o_tt + int'(o_ffvalid)), 0);
      end
      if (c <= nv * sp1 && o_stim != (c - 1) / sp1) stim_bad++;
      if (o_err) mask[c] = 1'b1;
      if (o_done) begin done_c = c; break; end
    end
    apply_ph = 1'b0;
  endtask

  typedef struct {
    int          sel;
    int          mode;
    int          done_c;
    logic [63:0] mask;
    int          ec;
    int          ffv;
    int          ffvalid;
    int          pass;
    int          tt;
  } vec_t;

  vec_t        tbl[7];
  int          dc, sb, n;
  logic [63:0] mk, inv_mask;

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode_a = 0; mode_b = 0; apply_ph = 1'b0; sel = 0;

    inv_mask = '0;
    for (int v = 0; v < 8; v++) inv_mask[(v + 1) * 3 + 1] = 1'b1;

    tbl[0] = '{0, 0, 25, 64'h0, 0, 0, 0, 1, 8};
    tbl[1] = '{0, 1, 25, (64'h1 << 7) | (64'h1 << 16), 2, 1, 1, 0, 8};
    tbl[2] = '{0, 2, 25, inv_mask, 8, 0, 1, 0, 8};
    tbl[3] = '{0, 0, 25, 64'h0, 0, 0, 0, 1, 8};
    tbl[4] = '{0, 3, 25, 64'h0, 0, 0, 0, 1, 8};
    tbl[5] = '{1, 0, 9, 64'h0, 0, 0, 0, 1, 4};
    tbl[6] = '{1, 1, 9, (64'h1 << 5) | (64'h1 << 7), 2, 1, 1, 0, 4};

    repeat (2) @(negedge clk);
    check("reset_outputs_a",
          longint'({stim_a, busy_a, done_a, pass_a, err_a, ec_a, tt_a, ffv_a, ffvalid_a}), 0);
    check("reset_outputs_b",
          longint'({stim_b, busy_b, done_b, pass_b, err_b, ec_b, tt_b, ffv_b, ffvalid_b}), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sel == 0) mode_a = tbl[i].mode; else mode_b = tbl[i].mode;
      run_test(tbl[i].sel, 1'b0, 40, dc, mk, sb);
      check($sformatf("row%0d_done_cycle", i), dc, tbl[i].done_c);
      check($sformatf("row%0d_error_mask", i), longint'(mk), longint'(tbl[i].mask));
      check($sformatf("row%0d_stim_trace", i), sb, 0);
      check($sformatf("row%0d_busy", i), longint'(o_busy), 0);
      check($sformatf("row%0d_error_count", i), o_ec, tbl[i].ec);
      check($sformatf("row%0d_total_tests", i), o_tt, tbl[i].tt);
      check($sformatf("row%0d_first_fail_vec", i), o_ffv, tbl[i].ffv);
      check($sformatf("row%0d_first_fail_valid", i), longint'(o_ffvalid), tbl[i].ffvalid);
      check($sformatf("row%0d_pass", i), longint'(o_pass), tbl[i].pass);
    end

    // Reset mid-run at cycle 10 with a stuck-at-0 DUT
    sel = 0; mode_a = 1;
    @(negedge clk); start_a = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("pre_reset_error_count", o_ec, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_outputs",
          longint'({stim_a, busy_a, done_a, pass_a, err_a, ec_a, tt_a, ffv_a, ffvalid_a}), 0);
    repeat (3) @(negedge clk);
    check("idle_after_reset", longint'({busy_a, done_a, stim_a}), 0);
    mode_a = 0;
    run_test(0, 1'b0, 40, dc, mk, sb);
    check("post_reset_done_cycle", dc, 25);
    check("post_reset_pass", longint'(o_pass), 1);
    check("post_reset_stim_trace", sb, 0);

    // start held high: one full run, then restart on the edge after done rises
    run_test(0, 1'b1, 40, dc, mk, sb);
    check("hold_done_cycle", dc, 25);
    check("hold_stim_trace", sb, 0);
    check("hold_pass", longint'(o_pass), 1);
    @(negedge clk);
    start_a = 1'b0;
    check("hold_restart_done", longint'(o_done), 0);
    check("hold_restart_busy", longint'(o_busy), 1);
    check("hold_restart_total", o_tt, 0);
    n = 0;
    while (!o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_second_run_len", n, 24);
    check("hold_second_pass", longint'(o_pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
